// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_e  : controller FSM encoding (IDLE / RUN / DONE)
//   SLICE_W  : width of the shared adder slice in bits
//   clog2    : ceiling log2 (minimum 1) used to size the nibble index
package nibble_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned SLICE_W = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_rca.sv
// 4-bit ripple-carry adder slice.
//   a, b  : 4-bit operands
//   cin   : carry in
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin
    logic [4:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Two-requester WIDTH-bit adder built around one shared 4-bit slice.
// A round-robin arbiter accepts one operand pair at a time; the add then
// runs one nibble per cycle (WIDTH/4 cycles) and the result is held until
// the consumer takes it.
//   clk, rst                     : clock, async active-high reset
//   req{0,1}_valid/_ready        : operand handshake (ready is combinational)
//   req{0,1}_a/_b/_cin           : operands and carry-in
//   res_valid/res_ready          : result handshake
//   res_sum/res_cout/res_id      : result, final carry, owning requester
//   busy                         : high while an add is running or held
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = clog2(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             ptr_q;
  logic             id_q;
  logic             res_valid_q;
  logic             res_cout_q;

  logic             any_valid;
  logic             grant;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // Grant goes to the sole valid requester; on contention, to the pointer.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) grant = ptr_q;
    else                          grant = req1_valid;
    req0_ready = (state_q == IDLE) & req0_valid & ~grant;
    req1_ready = (state_q == IDLE) & req1_valid &  grant;
  end

  // Operands are shifted right one nibble per step so the slice always sees
  // bits [3:0]; sum nibbles enter at the top and land in place after the
  // last step. Equivalent to indexing nibble idx, without a wide mux.
  ripple_carry_adder u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_q     <= grant ? req1_a   : req0_a;
            b_q     <= grant ? req1_b   : req0_b;
            carry_q <= grant ? req1_cin : req0_cin;
            id_q    <= grant;
            ptr_q   <= ~grant;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          sum_q   <= {slice_sum, sum_q[WIDTH-1:SLICE_W]};
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            res_valid_q <= 1'b1;
            res_cout_q  <= slice_cout;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        req0_valid, req0_ready, req0_cin;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, res_sum;
  logic        res_valid, res_ready, res_cout, res_id, busy;

  // WIDTH=32 instance
  logic        w_req0_valid, w_req0_ready, w_req0_cin;
  logic        w_req1_valid, w_req1_ready, w_req1_cin;
  logic [31:0] w_req0_a, w_req0_b, w_req1_a, w_req1_b, w_res_sum;
  logic        w_res_valid, w_res_ready, w_res_cout, w_res_id, w_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] sum;
    logic        cout;
  } exp_t;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(32)) dut_w32 (
    .clk(clk), .rst(rst),
    .req0_valid(w_req0_valid), .req0_ready(w_req0_ready),
    .req0_a(w_req0_a), .req0_b(w_req0_b), .req0_cin(w_req0_cin),
    .req1_valid(w_req1_valid), .req1_ready(w_req1_ready),
    .req1_a(w_req1_a), .req1_b(w_req1_b), .req1_cin(w_req1_cin),
    .res_valid(w_res_valid), .res_ready(w_res_ready),
    .res_sum(w_res_sum), .res_cout(w_res_cout), .res_id(w_res_id), .busy(w_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete 16-bit transaction on the chosen requester. lat is the
  // number of edges from accept to res_valid, or -1 on timeout.
  task automatic do_op16(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] s, output logic co,
                         output logic rid, output int lat);
    int n;
    lat = -1; s = '0; co = 1'b0; rid = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    res_ready = 1'b0;
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 30) begin tick(); n++; end
    if (n >= 30) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    if (!res_valid) return;
    s = res_sum; co = res_cout; rid = res_id; lat = n;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic drive(input int w, input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic c0, input logic c1, input logic rr);
    if (w == 16) begin
      req0_valid = v0; req0_a = a0[15:0]; req0_b = b0[15:0]; req0_cin = c0;
      req1_valid = v1; req1_a = a1[15:0]; req1_b = b1[15:0]; req1_cin = c1;
      res_ready = rr;
    end else begin
      w_req0_valid = v0; w_req0_a = a0; w_req0_b = b0; w_req0_cin = c0;
      w_req1_valid = v1; w_req1_a = a1; w_req1_b = b1; w_req1_cin = c1;
      w_res_ready = rr;
    end
  endtask

  task automatic sample(input int w, output logic r0, output logic r1, output logic rv,
                        output logic [31:0] s, output logic co, output logic id);
    if (w == 16) begin
      r0 = req0_ready; r1 = req1_ready; rv = res_valid;
      s = {16'h0000, res_sum}; co = res_cout; id = res_id;
    end else begin
      r0 = w_req0_ready; r1 = w_req1_ready; rv = w_res_valid;
      s = w_res_sum; co = w_res_cout; id = w_res_id;
    end
  endtask

  task automatic test_reset();
    drive(16, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(32, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_sum !== 16'h0000) begin errors++; $display("FAIL reset_res_sum got %h want 0000", res_sum); end
    checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL reset_res_cout got %b want 0", res_cout); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got %b want 0", res_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (w_res_valid !== 1'b0 || w_busy !== 1'b0) begin errors++; $display("FAIL reset_w32 got valid=%b busy=%b want 0 0", w_res_valid, w_busy); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_add();
    logic [15:0] s; logic co, id; int lat;
    do_op16(1'b0, 16'h00FF, 16'h0001, 1'b0, s, co, id, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++; if (s !== 16'h0100) begin errors++; $display("FAIL basic_sum got %h want 0100", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got %b want 0", co); end
    checks++; if (id !== 1'b0) begin errors++; $display("FAIL basic_id got %b want 0", id); end
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL basic_handoff got busy=%b valid=%b want 0 0", busy, res_valid); end
  endtask

  task automatic test_carry_wrap();
    logic [15:0] s; logic co, id; int lat;
    do_op16(1'b1, 16'hFFFF, 16'h0001, 1'b0, s, co, id, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wrap_latency got %0d want 4", lat); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL wrap_sum got %h want 0000", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL wrap_cout got %b want 1", co); end
    checks++; if (id !== 1'b1) begin errors++; $display("FAIL wrap_id got %b want 1", id); end
    do_op16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, s, co, id, lat);
    checks++; if (s !== 16'hFFFF) begin errors++; $display("FAIL allones_sum got %h want FFFF", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL allones_cout got %b want 1", co); end
    checks++; if (id !== 1'b1) begin errors++; $display("FAIL allones_id got %b want 1", id); end
  endtask

  task automatic test_round_robin();
    logic [15:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic        c0 [2], c1 [2];
    logic        exp_id   [4];
    logic [15:0] exp_sum  [4];
    logic        exp_cout [4];
    logic        acc0, acc1;
    int          n0, n1, nres;
    a0[0] = 16'h1234; b0[0] = 16'h1111; c0[0] = 1'b0;
    a0[1] = 16'h8000; b0[1] = 16'h8000; c0[1] = 1'b1;
    a1[0] = 16'hFFFF; b1[0] = 16'h0002; c1[0] = 1'b0;
    a1[1] = 16'h0F0F; b1[1] = 16'hF0F0; c1[1] = 1'b1;
    exp_id[0] = 1'b0; exp_sum[0] = 16'h2345; exp_cout[0] = 1'b0;
    exp_id[1] = 1'b1; exp_sum[1] = 16'h0001; exp_cout[1] = 1'b1;
    exp_id[2] = 1'b0; exp_sum[2] = 16'h0001; exp_cout[2] = 1'b1;
    exp_id[3] = 1'b1; exp_sum[3] = 16'h0000; exp_cout[3] = 1'b1;
    n0 = 0; n1 = 0; nres = 0;
    req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0]; req0_cin = c0[0];
    req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0]; req1_cin = c1[0];
    res_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 100 && nres < 4; cyc++) begin
      acc0 = req0_ready; acc1 = req1_ready;
      if (res_valid) begin
        checks++; if (res_id !== exp_id[nres]) begin errors++; $display("FAIL rr_id[%0d] got %b want %b", nres, res_id, exp_id[nres]); end
        checks++; if (res_sum !== exp_sum[nres]) begin errors++; $display("FAIL rr_sum[%0d] got %h want %h", nres, res_sum, exp_sum[nres]); end
        checks++; if (res_cout !== exp_cout[nres]) begin errors++; $display("FAIL rr_cout[%0d] got %b want %b", nres, res_cout, exp_cout[nres]); end
        nres++;
        if (nres == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      tick();
      if (acc0) begin n0++; if (n0 < 2) begin req0_a = a0[n0]; req0_b = b0[n0]; req0_cin = c0[n0]; end end
      if (acc1) begin n1++; if (n1 < 2) begin req1_a = a1[n1]; req1_b = b1[n1]; req1_cin = c1[n1]; end end
    end
    res_ready = 1'b0;
    checks++; if (nres !== 4) begin errors++; $display("FAIL rr_results got %0d want 4", nres); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_after got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int n;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    res_ready = 1'b0;
    #1;
    n = 0;
    while (!req0_ready && n < 30) begin tick(); n++; end
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_result_timeout got valid=%b want 1", res_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, res_valid); end
      checks++; if (res_sum !== 16'h0003) begin errors++; $display("FAIL bp_sum[%0d] got %h want 0003", i, res_sum); end
      checks++; if (res_cout !== 1'b0 || res_id !== 1'b0) begin errors++; $display("FAIL bp_cout_id[%0d] got %b %b want 0 0", i, res_cout, res_id); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b %b want 0 0", i, req0_ready, req1_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d] got %b want 1", i, busy); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", res_valid, busy); end
    checks++; if (res_sum !== 16'h0003) begin errors++; $display("FAIL bp_sum_kept got %h want 0003", res_sum); end
  endtask

  task automatic test_midrun_reset();
    logic [15:0] s; logic co, id; int lat, n, seen;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0;
    #1;
    n = 0;
    while (!req0_ready && n < 30) begin tick(); n++; end
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", res_valid); end
    checks++; if (res_sum !== 16'h0000 || res_cout !== 1'b0) begin errors++; $display("FAIL mr_sum_cout got %h %b want 0000 0", res_sum, res_cout); end
    checks++; if (res_id !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mr_id_busy got %b %b want 0 0", res_id, busy); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (res_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mr_no_result got %0d results want 0", seen); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mr_ptr_reset got %b %b want 1 0", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    do_op16(1'b0, 16'h0F0F, 16'h00F1, 1'b0, s, co, id, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mr_next_latency got %0d want 4", lat); end
    checks++; if (s !== 16'h1000) begin errors++; $display("FAIL mr_next_sum got %h want 1000", s); end
    checks++; if (co !== 1'b0 || id !== 1'b0) begin errors++; $display("FAIL mr_next_cout_id got %b %b want 0 0", co, id); end
  endtask

  task automatic test_random(input int w);
    exp_t        q [$];
    exp_t        e;
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        c [2];
    int          issued [2];
    int          accepted, results, n;
    logic        rr, r0, r1, rv, co, id;
    logic [31:0] s, mask;
    logic [32:0] full;
    mask = (w == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
    for (int k = 0; k < 2; k++) begin v[k] = 1'b0; a[k] = '0; b[k] = '0; c[k] = 1'b0; issued[k] = 0; end
    accepted = 0; results = 0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (issued[0] == 250 && issued[1] == 250 && !v[0] && !v[1] && q.size() == 0) break;
      for (int k = 0; k < 2; k++) begin
        if (!v[k] && issued[k] < 250 && $urandom_range(3) != 0) begin
          v[k] = 1'b1;
          a[k] = ($urandom_range(7) == 0) ? mask : ($urandom & mask);
          b[k] = $urandom & mask;
          c[k] = 1'($urandom_range(1));
          issued[k]++;
        end
      end
      rr = ($urandom_range(3) != 0);
      drive(w, v[0], v[1], a[0], b[0], a[1], b[1], c[0], c[1], rr);
      #1;
      sample(w, r0, r1, rv, s, co, id);
      if (r0 || r1) begin
        n = r1 ? 1 : 0;
        full = {1'b0, a[n]} + {1'b0, b[n]} + 33'(c[n]);
        e.id = r1;
        e.sum = full[31:0] & mask;
        e.cout = (w == 16) ? full[16] : full[32];
        q.push_back(e);
        accepted++;
      end
      if (rv && rr) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand%0d_extra_result got sum=%h id=%b want no result", w, s, id);
        end else begin
          e = q.pop_front();
          if (s !== e.sum || co !== e.cout || id !== e.id) begin
            errors++;
            $display("FAIL rand%0d_result[%0d] got sum=%h cout=%b id=%b want sum=%h cout=%b id=%b",
                     w, results, s, co, id, e.sum, e.cout, e.id);
          end
        end
        results++;
      end
      tick();
      if (r0) v[0] = 1'b0;
      if (r1) v[1] = 1'b0;
    end
    drive(w, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (accepted !== 500) begin errors++; $display("FAIL rand%0d_accepted got %0d want 500", w, accepted); end
    checks++; if (results !== 500) begin errors++; $display("FAIL rand%0d_results got %0d want 500", w, results); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand%0d_pending got %0d want 0", w, q.size()); end
    checks++; if ((w == 16 ? busy : w_busy) !== 1'b0) begin errors++; $display("FAIL rand%0d_idle_at_end got busy=1 want 0", w); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_wrap();
    test_round_robin();
    test_backpressure();
    test_midrun_reset();
    test_random(16);
    test_random(32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
